// File: rtl/fs_cap_pkg.sv
// Shared constants and types for the frame-start capture block.
//   EDGE_*        : edge selection codes for the per-channel edge detector
//   align_state_t : cross-channel aligner state
package fs_cap_pkg;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   typedef enum logic {
      IDLE,
      COLLECT
   } align_state_t;

endpackage

// File: rtl/fs_cap_mc_if.sv
// Bundle of the frame-start capture control/status signals.
//   master : sensor side / controller (drives vsync, enables, clear, timeout)
//   slave  : fs_cap_mc (drives captures, filtered levels, counters, flags)
interface fs_cap_mc_if #(
   parameter int CH_NUM = 4,
   parameter int FCNT_W = 16,
   parameter int TMO_W  = 24
);
   logic [CH_NUM-1:0]        vs_i;
   logic [CH_NUM-1:0]        ch_en_i;
   logic                     clr_i;
   logic [TMO_W-1:0]         timeout_i;
   logic [CH_NUM-1:0]        fs_cap_o;
   logic [CH_NUM-1:0]        vs_filt_o;
   logic [CH_NUM*FCNT_W-1:0] frame_cnt_o;
   logic [CH_NUM-1:0]        timeout_o;
   logic                     fs_all_o;
   logic                     align_err_o;

   modport master (
      output vs_i, ch_en_i, clr_i, timeout_i,
      input  fs_cap_o, vs_filt_o, frame_cnt_o, timeout_o, fs_all_o, align_err_o
   );

   modport slave (
      input  vs_i, ch_en_i, clr_i, timeout_i,
      output fs_cap_o, vs_filt_o, frame_cnt_o, timeout_o, fs_all_o, align_err_o
   );
endinterface

// File: rtl/fs_cap_ch.sv
// One vsync channel: synchroniser, glitch filter, edge detect, frame counter
// and lost-vsync watchdog.
//   clk_i, rstn_i : clock, async active-low reset
//   vs            : raw vsync (asynchronous)
//   en, clr       : channel enable, synchronous clear (counter + flag)
//   timeout       : watchdog limit, 0 disables
//   fs_cap        : edge pulse or gated filtered level
//   vs_filt       : filtered level, aligned with fs_cap
//   edge_pulse    : registered accepted-edge pulse (for the aligner)
//   frame_cnt     : accepted-edge count
//   timeout_flag  : sticky lost-vsync flag
module fs_cap_ch
   import fs_cap_pkg::*;
#(
   parameter int SYNC_STAGES  = 4,
   parameter int FILT_LEN     = 3,
   parameter int VIDEO_ENABLE = 1,
   parameter int EDGE_SEL     = EDGE_RISE,
   parameter int FCNT_W       = 16,
   parameter int TMO_W        = 24
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              vs,
   input  logic              en,
   input  logic              clr,
   input  logic [TMO_W-1:0]  timeout,
   output logic              fs_cap,
   output logic              vs_filt,
   output logic              edge_pulse,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              timeout_flag
);
   localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
   localparam bit         USE_RISE  = (EDGE_SEL != EDGE_FALL);
   localparam bit         USE_FALL  = (EDGE_SEL != EDGE_RISE);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   vs_s;
   logic [3:0]             cnt_q;
   logic                   filt_q;
   logic                   filt_prev_q;
   logic                   edge_acc;
   logic                   edge_q;
   logic                   lvl_q;
   logic [FCNT_W-1:0]      fcnt_q;
   logic [TMO_W-1:0]       wd_q;
   logic [TMO_W-1:0]       wd_inc;
   logic                   wd_run;
   logic                   tmo_q;

   assign vs_s     = sync_q[SYNC_STAGES-1];
   assign edge_acc = en & ((USE_RISE & filt_q & ~filt_prev_q) |
                           (USE_FALL & ~filt_q & filt_prev_q));
   assign wd_inc   = wd_q + 1'b1;
   // Watchdog advances only while enabled, not restarting, not saturated.
   assign wd_run   = en & ~edge_acc & (wd_q != '1);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         edge_q      <= 1'b0;
         lvl_q       <= 1'b0;
         fcnt_q      <= '0;
         wd_q        <= '0;
         tmo_q       <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], vs};

         // A mismatch run must last FILT_LEN cycles; shorter runs are dropped.
         if (vs_s != filt_q) begin
            if (cnt_q == FILT_LAST) begin
               filt_q <= ~filt_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
         end else begin
            cnt_q <= '0;
         end

         filt_prev_q <= filt_q;
         edge_q      <= edge_acc;
         lvl_q       <= filt_q & en;

         if (clr)
            fcnt_q <= '0;
         else if (edge_acc)
            fcnt_q <= fcnt_q + 1'b1;

         if (edge_acc)
            wd_q <= '0;
         else if (wd_run)
            wd_q <= wd_inc;

         // Flag rises on the same edge the count lands on the limit.
         if (clr)
            tmo_q <= 1'b0;
         else if (wd_run && (timeout != '0) && (wd_inc == timeout))
            tmo_q <= 1'b1;
      end
   end

   assign fs_cap       = (VIDEO_ENABLE != 0) ? edge_q : lvl_q;
   assign vs_filt      = filt_prev_q;
   assign edge_pulse   = edge_q;
   assign frame_cnt    = fcnt_q;
   assign timeout_flag = tmo_q;

endmodule

// File: rtl/fs_cap_mc.sv
// Multi-channel frame-start capture with cross-channel alignment check.
//   clk_i, rstn_i : clock, async active-low reset
//   bus (slave)   : vs_i, ch_en_i, clr_i, timeout_i in;
//                   fs_cap_o, vs_filt_o, frame_cnt_o, timeout_o,
//                   fs_all_o, align_err_o out
//
// Aligner states:
//   state   | meaning
//   IDLE    | no window open, waiting for the first accepted edge
//   COLLECT | window open, accumulating channels that have started a frame
module fs_cap_mc
   import fs_cap_pkg::*;
#(
   parameter int CH_NUM       = 4,
   parameter int SYNC_STAGES  = 4,
   parameter int FILT_LEN     = 3,
   parameter int VIDEO_ENABLE = 1,
   parameter int EDGE_SEL     = EDGE_RISE,
   parameter int FCNT_W       = 16,
   parameter int TMO_W        = 24,
   parameter int ALIGN_WIN    = 64
) (
   input logic         clk_i,
   input logic         rstn_i,
   fs_cap_mc_if.slave  bus
);
   localparam logic [15:0] WIN_LAST = 16'(ALIGN_WIN - 1);

   logic [CH_NUM-1:0]        cap;
   logic [CH_NUM-1:0]        filt;
   logic [CH_NUM-1:0]        edg;
   logic [CH_NUM-1:0]        tmo;
   logic [CH_NUM*FCNT_W-1:0] fcnt;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      fs_cap_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILT_LEN     (FILT_LEN),
         .VIDEO_ENABLE (VIDEO_ENABLE),
         .EDGE_SEL     (EDGE_SEL),
         .FCNT_W       (FCNT_W),
         .TMO_W        (TMO_W)
      ) u_ch (
         .clk_i        (clk_i),
         .rstn_i       (rstn_i),
         .vs           (bus.vs_i[g]),
         .en           (bus.ch_en_i[g]),
         .clr          (bus.clr_i),
         .timeout      (bus.timeout_i),
         .fs_cap       (cap[g]),
         .vs_filt      (filt[g]),
         .edge_pulse   (edg[g]),
         .frame_cnt    (fcnt[g*FCNT_W +: FCNT_W]),
         .timeout_flag (tmo[g])
      );
   end

   align_state_t      state_q, state_d;
   logic [CH_NUM-1:0] mask_q, mask_d;
   logic [15:0]       win_q, win_d;
   logic              fs_all_q, fs_all_d;
   logic              err_q, err_d;
   logic [CH_NUM-1:0] en;
   logic [CH_NUM-1:0] hits;
   logic              covered;

   assign en      = bus.ch_en_i;
   assign hits    = edg & en;
   // Evaluated against the current enable set so a channel disabled
   // mid-window drops out of the requirement.
   assign covered = ((mask_q | hits) & en) == en;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         win_q    <= '0;
         fs_all_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         win_q    <= win_d;
         fs_all_q <= fs_all_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      win_d    = win_q;
      fs_all_d = 1'b0;
      err_d    = 1'b0;
      if (bus.clr_i) begin
         state_d = IDLE;
         mask_d  = '0;
         win_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if ((en != '0) && (hits != '0)) begin
                  if (hits == en) begin
                     fs_all_d = 1'b1;
                  end else begin
                     state_d = COLLECT;
                     mask_d  = hits;
                     win_d   = 16'd1;
                  end
               end
            end
            COLLECT: begin
               if (en == '0) begin
                  state_d = IDLE;
                  mask_d  = '0;
               end else if (covered) begin
                  fs_all_d = 1'b1;
                  state_d  = IDLE;
                  mask_d   = '0;
               end else if (win_q >= WIN_LAST) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
                  mask_d  = '0;
               end else begin
                  mask_d = mask_q | hits;
                  win_d  = win_q + 16'd1;
               end
            end
            default: begin
               state_d = IDLE;
               mask_d  = '0;
            end
         endcase
      end
   end

   assign bus.fs_cap_o    = cap;
   assign bus.vs_filt_o   = filt;
   assign bus.frame_cnt_o = fcnt;
   assign bus.timeout_o   = tmo;
   assign bus.fs_all_o    = fs_all_q;
   assign bus.align_err_o = err_q;

endmodule

// File: tb/tb_fs_cap_mc.sv
module tb_fs_cap_mc;

   localparam int K_CAP = 0;
   localparam int K_ALL = 1;
   localparam int K_ERR = 2;
   localparam int K_TMO = 3;

   typedef struct {
      int kind;
      int ch;
      int cyc;
      int val;
   } ev_t;

   logic clk;
   logic rstn;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   b_pulses = 0;
   ev_t  exp_q[$];
   logic [3:0] tmo_prev = 4'b0;

   fs_cap_mc_if #(.CH_NUM(4), .FCNT_W(16), .TMO_W(24)) if_a ();
   fs_cap_mc_if #(.CH_NUM(1), .FCNT_W(4),  .TMO_W(24)) if_b ();

   fs_cap_mc dut_a (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (if_a)
   );

   fs_cap_mc #(
      .CH_NUM   (1),
      .EDGE_SEL (2),
      .FCNT_W   (4)
   ) dut_b (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int ch, input int c, input int val);
      ev_t e;
      e.kind = kind;
      e.ch   = ch;
      e.cyc  = c;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int ch, input int val);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_unexpected: got kind=%0d ch=%0d cyc=%0d val=%0d, expected no event",
                  kind, ch, cyc, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.ch != ch || e.cyc != cyc || e.val != val) begin
            n_err++;
            $display("FAIL sb_event: got kind=%0d ch=%0d cyc=%0d val=%0d, expected kind=%0d ch=%0d cyc=%0d val=%0d",
                     kind, ch, cyc, val, e.kind, e.ch, e.cyc, e.val);
         end
      end
   endtask

   // Monitor for dut_a: every output event is matched against the queue head.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++)
         if (if_a.fs_cap_o[i] === 1'b1)
            observe(K_CAP, i, int'(if_a.frame_cnt_o[i*16 +: 16]));
      if (if_a.fs_all_o === 1'b1)    observe(K_ALL, 0, 0);
      if (if_a.align_err_o === 1'b1) observe(K_ERR, 0, 0);
      for (int i = 0; i < 4; i++)
         if (if_a.timeout_o[i] === 1'b1 && tmo_prev[i] == 1'b0)
            observe(K_TMO, i, 0);
      tmo_prev = if_a.timeout_o;
   end

   always @(negedge clk)
      if (if_b.fs_cap_o[0] === 1'b1) b_pulses <= b_pulses + 1;

   initial begin
      int t;
      int base;
      rstn           = 1'b0;
      if_a.vs_i      = 4'b0;
      if_a.ch_en_i   = 4'b1111;
      if_a.clr_i     = 1'b0;
      if_a.timeout_i = 24'd1000;
      if_b.vs_i      = 1'b0;
      if_b.ch_en_i   = 1'b1;
      if_b.clr_i     = 1'b0;
      if_b.timeout_i = 24'd0;
      repeat (3) @(negedge clk);

      chk("rst_fs_cap",  64'(if_a.fs_cap_o), 0);
      chk("rst_vs_filt", 64'(if_a.vs_filt_o), 0);
      chk("rst_fcnt",    64'(if_a.frame_cnt_o), 0);
      chk("rst_tmo",     64'(if_a.timeout_o), 0);
      chk("rst_align",   64'({if_a.fs_all_o, if_a.align_err_o}), 0);

      // Watchdog: no vsync, limit 1000 -> all four flags at cycle 1000.
      rstn = 1'b1;
      t = cyc;
      for (int i = 0; i < 4; i++) push(K_TMO, i, t + 1000, 0);
      repeat (999) @(negedge clk);
      chk("tmo_early", 64'(if_a.timeout_o), 0);
      repeat (6) @(negedge clk);

      // Single rising edge on ch0 (only ch0 enabled -> immediate fs_all).
      if_a.ch_en_i = 4'b0001;
      if_a.vs_i    = 4'b0001;
      t = cyc;
      push(K_CAP, 0, t + 8, 1);
      push(K_ALL, 0, t + 9, 0);
      repeat (100) @(negedge clk);
      if_a.vs_i = 4'b0000;
      repeat (20) @(negedge clk);
      chk("tmo_sticky", 64'(if_a.timeout_o), 64'hF);
      chk("fcnt_ch0_1", 64'(if_a.frame_cnt_o[15:0]), 1);
      if_a.clr_i = 1'b1;
      @(negedge clk);
      if_a.clr_i     = 1'b0;
      if_a.timeout_i = 24'd0;
      chk("tmo_clr",  64'(if_a.timeout_o), 0);
      chk("fcnt_clr", 64'(if_a.frame_cnt_o[15:0]), 0);

      // Glitch: 2-cycle pulse on ch1 must be rejected.
      if_a.ch_en_i = 4'b0011;
      if_a.vs_i    = 4'b0010;
      repeat (2) @(negedge clk);
      if_a.vs_i = 4'b0000;
      repeat (20) @(negedge clk);
      chk("glitch_filt", 64'(if_a.vs_filt_o[1]), 0);
      chk("glitch_fcnt", 64'(if_a.frame_cnt_o[31:16]), 0);

      // Alignment: ch0, ch2, ch1 at 0, 10, 40 -> fs_all at 41.
      if_a.ch_en_i = 4'b0111;
      t = cyc;
      if_a.vs_i = 4'b0001;
      push(K_CAP, 0, t + 8, 1);
      repeat (10) @(negedge clk);
      if_a.vs_i = 4'b0101;
      push(K_CAP, 2, t + 18, 1);
      repeat (30) @(negedge clk);
      if_a.vs_i = 4'b0111;
      push(K_CAP, 1, t + 48, 1);
      push(K_ALL, 0, t + 49, 0);
      repeat (30) @(negedge clk);
      if_a.vs_i = 4'b0000;
      repeat (20) @(negedge clk);

      // Missing ch1 -> align_err 64 cycles after the first capture.
      t = cyc;
      if_a.vs_i = 4'b0001;
      push(K_CAP, 0, t + 8, 2);
      repeat (10) @(negedge clk);
      if_a.vs_i = 4'b0101;
      push(K_CAP, 2, t + 18, 2);
      push(K_ERR, 0, t + 72, 0);
      repeat (80) @(negedge clk);
      if_a.vs_i = 4'b0000;
      repeat (20) @(negedge clk);

      // Disabling the missing channel mid-window completes the set.
      t = cyc;
      if_a.vs_i = 4'b0001;
      push(K_CAP, 0, t + 8, 3);
      repeat (10) @(negedge clk);
      if_a.vs_i = 4'b0101;
      push(K_CAP, 2, t + 18, 3);
      repeat (20) @(negedge clk);
      if_a.ch_en_i = 4'b0101;
      push(K_ALL, 0, t + 31, 0);
      repeat (10) @(negedge clk);
      if_a.ch_en_i = 4'b0111;
      if_a.vs_i    = 4'b0000;
      repeat (20) @(negedge clk);

      // All enabled channels edge in the same cycle.
      t = cyc;
      if_a.vs_i = 4'b0111;
      push(K_CAP, 0, t + 8, 4);
      push(K_CAP, 1, t + 8, 2);
      push(K_CAP, 2, t + 8, 4);
      push(K_ALL, 0, t + 9, 0);
      repeat (20) @(negedge clk);
      if_a.vs_i = 4'b0000;
      repeat (20) @(negedge clk);

      // Async reset with the aligner collecting and ch2 mid-filter.
      t = cyc;
      if_a.vs_i = 4'b0001;
      push(K_CAP, 0, t + 8, 5);
      repeat (20) @(negedge clk);
      if_a.vs_i = 4'b0101;
      repeat (5) @(negedge clk);
      chk("pre_rst_filt", 64'(if_a.vs_filt_o), 64'h1);
      chk("pre_rst_fcnt", 64'(if_a.frame_cnt_o[15:0]), 5);
      #2 rstn = 1'b0;
      #1;
      chk("arst_filt",  64'(if_a.vs_filt_o), 0);
      chk("arst_fcnt",  64'(if_a.frame_cnt_o), 0);
      chk("arst_cap",   64'(if_a.fs_cap_o), 0);
      chk("arst_align", 64'({if_a.fs_all_o, if_a.align_err_o}), 0);
      @(negedge clk);
      if_a.ch_en_i = 4'b0101;
      rstn = 1'b1;
      t = cyc;
      push(K_CAP, 0, t + 8, 1);
      push(K_CAP, 2, t + 8, 1);
      push(K_ALL, 0, t + 9, 0);
      repeat (30) @(negedge clk);
      if_a.vs_i = 4'b0000;
      repeat (20) @(negedge clk);

      // dut_b: both edges, 4-bit counter wrap, clear beats a same-cycle edge.
      base = b_pulses;
      for (int i = 0; i < 8; i++) begin
         if_b.vs_i = 1'b1;
         repeat (10) @(negedge clk);
         if (i == 7) chk("b_fcnt_15", 64'(if_b.frame_cnt_o), 15);
         if_b.vs_i = 1'b0;
         repeat (10) @(negedge clk);
         if (i == 0) chk("b_fcnt_2", 64'(if_b.frame_cnt_o), 2);
      end
      chk("b_pulses_16", 64'(b_pulses - base), 16);
      chk("b_fcnt_wrap", 64'(if_b.frame_cnt_o), 0);
      if_b.vs_i = 1'b1;
      repeat (7) @(negedge clk);
      if_b.clr_i = 1'b1;
      @(negedge clk);
      if_b.clr_i = 1'b0;
      chk("b_cap_17",  64'(if_b.fs_cap_o), 1);
      chk("b_fcnt_clr", 64'(if_b.frame_cnt_o), 0);
      repeat (5) @(negedge clk);
      chk("b_pulses_17", 64'(b_pulses - base), 17);

      chk("sb_pending", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fs_cap_mc.md
# fs_cap_mc

Multi-channel frame-start capture for the video stream DMA front end. Each channel resynchronises a raw vsync, glitch-filters it, detects the configured edge, and emits either a one-cycle frame-start pulse or a filtered level. It also keeps a per-channel frame counter and a lost-vsync watchdog. A cross-channel aligner reports when all enabled sensors start a frame within a window. It sits between the sensor inputs and the DMA write controllers / multi-camera frame arbiter.

## Interface
- CH_NUM, 4: number of vsync channels (1..8)
- SYNC_STAGES, 4: synchroniser flops per channel (2..6)
- FILT_LEN, 3: consecutive cycles a new level must persist before acceptance (1..15)
- VIDEO_ENABLE, 1: 1 = fs_cap_o is an edge pulse; 0 = fs_cap_o is the filtered level
- EDGE_SEL, 0: 0 rising, 1 falling, 2 both
- FCNT_W, 16: frame counter width
- TMO_W, 24: watchdog counter / timeout width
- ALIGN_WIN, 64: alignment window in cycles (1..2^16-1)
- clk_i  in  1  single clock; all logic in this domain
- rstn_i  in  1  reset; asynchronous, active-low
- vs_i  in  CH_NUM  raw vsync, asynchronous to clk_i
- ch_en_i  in  CH_NUM  channel enable, synchronous
- clr_i  in  1  synchronous one-cycle clear of frame counters, timeout flags and aligner
- timeout_i  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog
- fs_cap_o  out  CH_NUM  per-channel frame start (pulse or level, per VIDEO_ENABLE)
- vs_filt_o  out  CH_NUM  filtered vsync level
- frame_cnt_o  out  CH_NUM*FCNT_W  per-channel accepted-edge count; channel n at [n*FCNT_W +: FCNT_W]
- timeout_o  out  CH_NUM  sticky per-channel lost-vsync flag
- fs_all_o  out  1  one-cycle pulse: all enabled channels started within ALIGN_WIN
- align_err_o  out  1  one-cycle pulse: window expired with channels missing

## Operation
- Reset: all sync flops, filtered levels, counters, flags and outputs go to 0. The aligner goes to IDLE.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel. It runs regardless of ch_en_i.
- Filter: when the synchronised value differs from vs_filt, a mismatch counter increments; otherwise it clears to 0.
  - When the counter reaches FILT_LEN, vs_filt toggles and the counter clears.
  - Any mismatch run shorter than FILT_LEN is discarded.
- Edge: registered previous vs_filt compared with current, qualified by EDGE_SEL and ch_en_i.
- fs_cap_o:
  - VIDEO_ENABLE=1: registered one-cycle pulse per accepted edge.
  - VIDEO_ENABLE=0: registered copy of vs_filt, gated by ch_en_i.
- Frame counter: +1 per accepted edge, wraps modulo 2^FCNT_W. It holds while the channel is disabled. clr_i zeroes it; clr_i wins over a same-cycle edge.
- Watchdog: counts cycles since the last accepted edge and saturates at all-ones.
  - When the count equals timeout_i (nonzero), timeout_o sets.
  - An accepted edge restarts the count but does not clear the flag. Only clr_i or reset clears timeout_o.
  - A disabled channel holds its count.
- Aligner FSM, states IDLE and COLLECT:
  - IDLE -> COLLECT on any accepted edge: seen mask = the edge vector; window counter = 1.
  - If every enabled channel edges in the same cycle, fs_all_o pulses directly and the FSM stays in IDLE.
  - COLLECT: OR new edges into the mask; repeat edges from a seen channel are ignored.
    - When mask covers ch_en_i: pulse fs_all_o, go to IDLE.
    - Else, when the window counter reaches ALIGN_WIN: pulse align_err_o, go to IDLE.
    - Completion and expiry in the same cycle: completion wins.
  - ch_en_i all zero: the FSM stays in IDLE.
  - Disabling a channel mid-COLLECT removes it from the required set.
  - clr_i forces IDLE without pulses.

## Timing
- Latency, vs_i transition to fs_cap_o/vs_filt_o change: SYNC_STAGES + FILT_LEN + 1 cycles (defaults: 8). The input must stay stable for that period.
- frame_cnt_o updates in the same cycle fs_cap_o pulses.
- fs_all_o is asserted 1 cycle after the fs_cap_o pulse that completes the set.
- timeout_o rises the cycle the watchdog count equals timeout_i.
- Minimum accepted vsync pulse width: FILT_LEN cycles. Minimum edge-to-edge spacing per channel: FILT_LEN cycles.

## Structure
- Package fs_cap_pkg holds:
  - EDGE_RISE/EDGE_FALL/EDGE_BOTH constants
  - the aligner state typedef (IDLE, COLLECT)
- Sub-module fs_cap_ch: one channel (sync, filter, edge, frame counter, watchdog). It is instantiated CH_NUM times by generate.
- The aligner lives in the top level.

## Test plan
- Defaults: vs_i[0] 0->1, held 100 cycles -> fs_cap_o[0] high for exactly 1 cycle, 8 cycles after the first sample edge; frame_cnt 0->1.
- Glitch: vs_i[1] high for 2 cycles with FILT_LEN=3 -> no fs_cap_o, vs_filt_o stays 0, counter unchanged.
- EDGE_SEL=2, VIDEO_ENABLE=1, FCNT_W=4: 8 full vsync periods -> 16 pulses; counter wraps to 0; clr_i coinciding with the 17th edge -> counter 0.
- Watchdog: timeout_i=1000, no vsync -> timeout_o set at cycle 1000. A later edge leaves it set; clr_i clears it.
- Alignment, ch_en_i=4'b0111: edges on channels 0, 2, 1 at cycles 0, 10, 40 -> fs_all_o at 41. Repeat omitting channel 1 -> align_err_o at cycle 64, no fs_all_o.
- Reset mid-COLLECT and mid-filter: drop rstn_i asynchronously -> all outputs 0 immediately. After release, a held-high vs_i produces a fresh edge after 8 cycles.
